reg_write_queue: RTL and testbench
==================================

REG_WRITE_QUEUE -- requirements
Module: reg_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter REG_NUM_WIDTH, default 3, register number width (8 registers).
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- aluValid  in  1  ALU write request
- aluNum  in  REG_NUM_WIDTH  ALU destination register
- aluData  in  DATA_WIDTH  ALU result
- aluReady  out  1  ALU request accepted this cycle when aluValid&aluReady
- ldValid  in  1  load write request
- ldNum  in  REG_NUM_WIDTH  load destination register
- ldData  in  DATA_WIDTH  load result
- ldReady  out  1  load request accepted when ldValid&ldReady
- wrData  out  DATA_WIDTH  register-file write data
- wrNum  out  REG_NUM_WIDTH  register-file write number
- regWrite  out  1  register-file write enable
- rdNumA, rdNumB  in  REG_NUM_WIDTH  decode-stage source registers
- hazardA, hazardB  out  1  pending write to rdNumA/rdNumB
- fwdValidA, fwdValidB  out  1  forwarded data valid
- fwdDataA, fwdDataB  out  DATA_WIDTH  forwarded data
- count  out  clog2(DEPTH)+1  occupied queue entries

Function
REQ-005 SHALL hold accepted writes as {num,data} in an in-order FIFO of DEPTH entries.
REQ-006 SHALL compute free = DEPTH - count from registered count only; same-cycle drain gives no credit.
REQ-007 SHALL drive aluReady = (free >= 1).
REQ-008 SHALL drive ldReady = (free >= 2) | (free >= 1 & !aluValid).
REQ-009 SHALL, on simultaneous acceptance, enqueue ALU entry before load entry (ALU older).
REQ-010 SHALL complete handshake for requests with num 0 but discard them (not enqueued, count unchanged).
REQ-011 SHALL, each edge where count > 0 (pre-edge), pop head into output register: regWrite<=1, wrNum/wrData<=head; otherwise regWrite<=0, wrNum/wrData hold.
REQ-012 SHALL give latency: request accepted at edge E into empty queue -> regWrite high for exactly the cycle after edge E+1.
REQ-013 SHALL allow enqueue and pop on the same edge; count' = count + accepted - popped.
REQ-014 SHALL, when count == DEPTH, drive aluReady = ldReady = 0; no entry overwritten.
REQ-015 SHALL wrap FIFO pointers modulo DEPTH without loss or duplication.
REQ-016 SHALL drive hazardX = 1 iff rdNumX != 0 and matches any valid queue entry or the output register while regWrite = 1; combinational, same-cycle inputs excluded.
REQ-017 SHALL write register file in exact acceptance order; for repeated destinations the last accepted value is written last.

Reset
REQ-018 SHALL, on rst high at rising edge, set count 0, pointers 0, regWrite 0, wrNum 0, wrData 0.
REQ-019 SHALL discard all pending entries on mid-operation reset; no regWrite in cycle after reset edge.
REQ-020 SHALL give rst priority over simultaneous enqueue; requests that cycle are not accepted (aluReady/ldReady forced 0 while rst high).
REQ-021 SHALL drive hazardA/B, fwdValidA/B 0 and fwdDataA/B 0 following reset.

Configuration
REQ-022 SHALL compile forwarding only when macro REG_WRITE_QUEUE_BYPASS_EN is defined.
REQ-023 SHALL, with REG_WRITE_QUEUE_BYPASS_EN, drive fwdValidX = hazardX and fwdDataX = data of youngest matching entry (queue tail-most, else output register).
REQ-024 SHALL, without REG_WRITE_QUEUE_BYPASS_EN, keep ports present and tie fwdValidA/B and fwdDataA/B to 0; hazard logic unchanged.

Verification
REQ-025 Single write: aluValid, aluNum=3, aluData=0x12 at edge 1 -> regWrite=1, wrNum=3, wrData=0x12 in cycle after edge 2 only.
REQ-026 Dual accept: both valid, alu r1=0xA, ld r2=0xB, empty queue -> both ready, writes r1 then r2 on consecutive cycles.
REQ-027 Full: 4 ALU writes with no drain gap (DEPTH 4) -> count peaks per REQ-013, aluReady low at count 4, all 4 written in order.
REQ-028 Zero register: aluNum=0, aluData=0xFF -> aluReady=1, count stays 0, no regWrite, hazard never set for r0.
REQ-029 Hazard/forward: queue r5=0x1 then r5=0x2, rdNumA=5 -> hazardA=1; with macro fwdDataA=0x2, without macro fwdValidA=0, fwdDataA=0.
REQ-030 Reset mid-operation: 3 entries queued, rst high one edge -> count 0, regWrite 0, no pending entry ever written.

Source files
------------

// File: rtl/reg_write_queue.sv
// Register write-back queue: merges ALU and load results into an in-order FIFO
// drained one entry per cycle into the register file, with hazard detection.
// Optional forwarding of pending data is compiled in with REG_WRITE_QUEUE_BYPASS_EN.
module reg_write_queue #(
    parameter int DEPTH         = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       aluValid,
    input  logic [REG_NUM_WIDTH-1:0]   aluNum,
    input  logic [DATA_WIDTH-1:0]      aluData,
    output logic                       aluReady,
    input  logic                       ldValid,
    input  logic [REG_NUM_WIDTH-1:0]   ldNum,
    input  logic [DATA_WIDTH-1:0]      ldData,
    output logic                       ldReady,
    output logic [DATA_WIDTH-1:0]      wrData,
    output logic [REG_NUM_WIDTH-1:0]   wrNum,
    output logic                       regWrite,
    input  logic [REG_NUM_WIDTH-1:0]   rdNumA,
    input  logic [REG_NUM_WIDTH-1:0]   rdNumB,
    output logic                       hazardA,
    output logic                       hazardB,
    output logic                       fwdValidA,
    output logic                       fwdValidB,
    output logic [DATA_WIDTH-1:0]      fwdDataA,
    output logic [DATA_WIDTH-1:0]      fwdDataB,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [REG_NUM_WIDTH-1:0] mem_num_q  [DEPTH];
    logic [REG_NUM_WIDTH-1:0] mem_num_d  [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data_q [DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data_d [DEPTH];

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     reg_write_q, reg_write_d;
    logic [REG_NUM_WIDTH-1:0] wr_num_q, wr_num_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;

    logic [CW-1:0]            free;
    logic                     alu_ready, ld_ready;
    logic                     alu_enq, ld_enq, pop;
    logic [PW-1:0]            ld_slot;

    logic [PW-1:0]            slot_idx   [DEPTH];
    logic                     slot_valid [DEPTH];
    logic [REG_NUM_WIDTH-1:0] rd_num     [2];
    logic                     hit        [2];
    logic [DATA_WIDTH-1:0]    fwd_data   [2];

    // Credit comes only from the registered count; a same-cycle pop is not counted.
    assign free      = CW'(DEPTH) - count_q;
    assign alu_ready = !rst && (free >= CW'(1));
    assign ld_ready  = !rst && ((free >= CW'(2)) || ((free >= CW'(1)) && !aluValid));

    // Register 0 requests handshake normally but never occupy a slot.
    assign alu_enq = aluValid && alu_ready && (aluNum != '0);
    assign ld_enq  = ldValid && ld_ready && (ldNum != '0);
    assign pop     = (count_q != '0);
    assign ld_slot = wr_ptr_q + PW'(alu_enq);

    always_comb begin
        mem_num_d  = mem_num_q;
        mem_data_d = mem_data_q;
        if (alu_enq) begin
            mem_num_d[wr_ptr_q]  = aluNum;
            mem_data_d[wr_ptr_q] = aluData;
        end
        if (ld_enq) begin
            mem_num_d[ld_slot]  = ldNum;
            mem_data_d[ld_slot] = ldData;
        end
        wr_ptr_d = wr_ptr_q + PW'(alu_enq) + PW'(ld_enq);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(alu_enq) + CW'(ld_enq) - CW'(pop);
    end

    always_comb begin
        reg_write_d = pop;
        wr_num_d    = wr_num_q;
        wr_data_d   = wr_data_q;
        if (pop) begin
            wr_num_d  = mem_num_q[rd_ptr_q];
            wr_data_d = mem_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            wr_num_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            wr_num_q    <= wr_num_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Slot storage carries no control meaning; validity comes from count/pointers.
    always_ff @(posedge clk) begin
        mem_num_q  <= mem_num_d;
        mem_data_q <= mem_data_d;
    end

    // Slots listed oldest first so a later match overrides an earlier one.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_idx[i]   = rd_ptr_q + PW'(i);
            slot_valid[i] = (CW'(i) < count_q);
        end
    end

    always_comb begin
        rd_num[0] = rdNumA;
        rd_num[1] = rdNumB;
        for (int p = 0; p < 2; p++) begin
            hit[p]      = 1'b0;
            fwd_data[p] = '0;
            if (reg_write_q && (wr_num_q == rd_num[p])) begin
                hit[p] = 1'b1;
`ifdef REG_WRITE_QUEUE_BYPASS_EN
                fwd_data[p] = wr_data_q;
`endif
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (mem_num_q[slot_idx[i]] == rd_num[p])) begin
                    hit[p] = 1'b1;
`ifdef REG_WRITE_QUEUE_BYPASS_EN
                    fwd_data[p] = mem_data_q[slot_idx[i]];
`endif
                end
            end
            if (rd_num[p] == '0) begin
                hit[p]      = 1'b0;
                fwd_data[p] = '0;
            end
        end
    end

    assign aluReady = alu_ready;
    assign ldReady  = ld_ready;
    assign regWrite = reg_write_q;
    assign wrNum    = wr_num_q;
    assign wrData   = wr_data_q;
    assign count    = count_q;
    assign hazardA  = hit[0];
    assign hazardB  = hit[1];

`ifdef REG_WRITE_QUEUE_BYPASS_EN
    assign fwdValidA = hit[0];
    assign fwdValidB = hit[1];
    assign fwdDataA  = fwd_data[0];
    assign fwdDataB  = fwd_data[1];
`else
    assign fwdValidA = 1'b0;
    assign fwdValidB = 1'b0;
    assign fwdDataA  = '0;
    assign fwdDataB  = '0;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Self-checking bench for reg_write_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_reg_write_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int NW    = 3;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef REG_WRITE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          aluValid, ldValid;
    logic [NW-1:0] aluNum, ldNum, rdNumA, rdNumB;
    logic [DW-1:0] aluData, ldData;
    logic          aluReady, ldReady, regWrite;
    logic [DW-1:0] wrData, fwdDataA, fwdDataB;
    logic [NW-1:0] wrNum;
    logic          hazardA, hazardB, fwdValidA, fwdValidB;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .REG_NUM_WIDTH(NW)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluNum(aluNum), .aluData(aluData), .aluReady(aluReady),
        .ldValid(ldValid), .ldNum(ldNum), .ldData(ldData), .ldReady(ldReady),
        .wrData(wrData), .wrNum(wrNum), .regWrite(regWrite),
        .rdNumA(rdNumA), .rdNumB(rdNumB), .hazardA(hazardA), .hazardB(hazardB),
        .fwdValidA(fwdValidA), .fwdValidB(fwdValidB),
        .fwdDataA(fwdDataA), .fwdDataB(fwdDataB), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes in acceptance order plus the output register.
    typedef struct {
        logic [NW-1:0] num;
        logic [DW-1:0] data;
    } ent_t;
    ent_t          mq[$];
    logic          m_rw;
    logic [NW-1:0] m_num;
    logic [DW-1:0] m_data;

    function automatic logic exp_alu_ready();
        return !rst && ((DEPTH - mq.size()) >= 1);
    endfunction

    function automatic logic exp_ld_ready();
        int fr = DEPTH - mq.size();
        return !rst && ((fr >= 2) || ((fr >= 1) && !aluValid));
    endfunction

    function automatic logic exp_haz(input logic [NW-1:0] n);
        if (n == 0) return 1'b0;
        if (m_rw && m_num == n) return 1'b1;
        foreach (mq[i]) if (mq[i].num == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] exp_fwd(input logic [NW-1:0] n);
        if (!BYP || !exp_haz(n)) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].num == n) return mq[i].data;
        return m_data;
    endfunction

    task automatic set_in(input logic av, input logic [NW-1:0] an, input logic [DW-1:0] ad,
                          input logic lv, input logic [NW-1:0] ln, input logic [DW-1:0] ld);
        aluValid = av; aluNum = an; aluData = ad;
        ldValid  = lv; ldNum  = ln; ldData  = ld;
    endtask

    task automatic tick();
        int   fr;
        logic ar, lr;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rw = 1'b0; m_num = '0; m_data = '0;
        end else begin
            fr = DEPTH - mq.size();
            ar = (fr >= 1);
            lr = (fr >= 2) || ((fr >= 1) && !aluValid);
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_rw = 1'b1; m_num = e.num; m_data = e.data;
            end else begin
                m_rw = 1'b0;
            end
            if (aluValid && ar && aluNum != 0) mq.push_back('{aluNum, aluData});
            if (ldValid && lr && ldNum != 0) mq.push_back('{ldNum, ldData});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 3'd1, 32'h1, 1'b1, 3'd2, 32'h2);
        rdNumA = 3'd1; rdNumB = 3'd2;
        #1;
        n_checks++;
        if ({aluReady, ldReady} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready got=%b want=00", {aluReady, ldReady});
        end
        tick(); tick();
        n_checks++;
        if ({count, regWrite, wrNum, wrData} !== '0) begin
            n_fail++; $display("FAIL reset_state cnt=%0d rw=%b num=%0d data=%h want all 0",
                               count, regWrite, wrNum, wrData);
        end
        n_checks++;
        if ({hazardA, hazardB, fwdValidA, fwdValidB, fwdDataA, fwdDataB} !== '0) begin
            n_fail++; $display("FAIL reset_hazfwd haz=%b%b fv=%b%b fa=%h fb=%h want 0",
                               hazardA, hazardB, fwdValidA, fwdValidB, fwdDataA, fwdDataB);
        end
        rst = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        rdNumA = '0; rdNumB = '0;
        #1;
    endtask

    task automatic test_single_write();
        set_in(1'b1, 3'd3, 32'h12, 1'b0, '0, '0);
        #1;
        n_checks++;
        if (aluReady !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b want=1", aluReady); end
        tick();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({regWrite, count} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL single_e1 rw=%b cnt=%0d want rw=0 cnt=1", regWrite, count);
        end
        tick();
        n_checks++;
        if ({regWrite, wrNum, wrData, count} !== {1'b1, 3'd3, 32'h12, 3'd0}) begin
            n_fail++; $display("FAIL single_e2 rw=%b num=%0d data=%h cnt=%0d want 1/3/12/0",
                               regWrite, wrNum, wrData, count);
        end
        tick();
        n_checks++;
        if ({regWrite, wrNum, wrData} !== {1'b0, 3'd3, 32'h12}) begin
            n_fail++; $display("FAIL single_e3 rw=%b num=%0d data=%h want 0/3/12 held", regWrite, wrNum, wrData);
        end
    endtask

    task automatic test_dual_accept();
        set_in(1'b1, 3'd1, 32'hA, 1'b1, 3'd2, 32'hB);
        #1;
        n_checks++;
        if ({aluReady, ldReady} !== 2'b11) begin
            n_fail++; $display("FAIL dual_ready got=%b want=11", {aluReady, ldReady});
        end
        tick();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if (count !== 3'd2) begin n_fail++; $display("FAIL dual_count got=%0d want=2", count); end
        tick();
        n_checks++;
        if ({regWrite, wrNum, wrData} !== {1'b1, 3'd1, 32'hA}) begin
            n_fail++; $display("FAIL dual_first rw=%b num=%0d data=%h want 1/1/A", regWrite, wrNum, wrData);
        end
        tick();
        n_checks++;
        if ({regWrite, wrNum, wrData} !== {1'b1, 3'd2, 32'hB}) begin
            n_fail++; $display("FAIL dual_second rw=%b num=%0d data=%h want 1/2/B", regWrite, wrNum, wrData);
        end
        tick();
        n_checks++;
        if (regWrite !== 1'b0) begin n_fail++; $display("FAIL dual_idle rw=%b want=0", regWrite); end
    endtask

    task automatic test_back_to_back();
        int got;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, NW'(k + 1), 32'h100 + k, 1'b0, '0, '0);
            #1;
            n_checks++;
            if (aluReady !== exp_alu_ready()) begin
                n_fail++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, aluReady, exp_alu_ready());
            end
            tick();
            n_checks++;
            if (count !== CW'(mq.size())) begin
                n_fail++; $display("FAIL b2b_count k=%0d got=%0d want=%0d", k, count, mq.size());
            end
            if (regWrite) begin
                n_checks++;
                if ({wrNum, wrData} !== {NW'(got + 1), 32'h100 + got}) begin
                    n_fail++; $display("FAIL b2b_order idx=%0d num=%0d data=%h", got, wrNum, wrData);
                end
                got++;
            end
        end
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        for (int c = 0; c < 8 && got < 4; c++) begin
            tick();
            if (regWrite) begin
                n_checks++;
                if ({wrNum, wrData} !== {NW'(got + 1), 32'h100 + got}) begin
                    n_fail++; $display("FAIL b2b_order idx=%0d num=%0d data=%h", got, wrNum, wrData);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 4) begin n_fail++; $display("FAIL b2b_drain writes=%0d want=4", got); end
        tick(); tick();
    endtask

    task automatic test_zero_reg();
        set_in(1'b1, 3'd0, 32'hFF, 1'b0, '0, '0);
        rdNumA = 3'd0;
        #1;
        n_checks++;
        if ({aluReady, hazardA} !== 2'b10) begin
            n_fail++; $display("FAIL zero_ready rdy=%b haz=%b want 1/0", aluReady, hazardA);
        end
        tick();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({count, hazardA} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL zero_count cnt=%0d haz=%b want 0/0", count, hazardA);
        end
        tick();
        n_checks++;
        if ({regWrite, hazardA} !== 2'b00) begin
            n_fail++; $display("FAIL zero_nowrite rw=%b haz=%b want 0/0", regWrite, hazardA);
        end
    endtask

    task automatic test_hazard_fwd();
        logic          want_h [4];
        logic [DW-1:0] want_d [4];
        want_h = '{1'b1, 1'b1, 1'b1, 1'b0};
        want_d = '{BYP ? 32'h2 : 32'h0, BYP ? 32'h2 : 32'h0, BYP ? 32'h2 : 32'h0, 32'h0};
        set_in(1'b1, 3'd5, 32'h1, 1'b1, 3'd5, 32'h2);
        rdNumA = 3'd5; rdNumB = 3'd6;
        #1;
        n_checks++;
        if ({hazardA, hazardB} !== 2'b00) begin
            n_fail++; $display("FAIL haz_same_cycle haz=%b%b want 00", hazardA, hazardB);
        end
        tick();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        for (int s = 0; s < 4; s++) begin
            #1;
            n_checks++;
            if ({hazardA, hazardB, fwdValidA, fwdDataA} !== {want_h[s], 1'b0, want_h[s] & BYP, want_d[s]}) begin
                n_fail++; $display("FAIL haz_step%0d hA=%b hB=%b fvA=%b fdA=%h want hA=%b fdA=%h",
                                   s, hazardA, hazardB, fwdValidA, fwdDataA, want_h[s], want_d[s]);
            end
            tick();
        end
        rdNumA = '0; rdNumB = '0;
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
        tick();
        set_in(1'b1, 3'd3, 32'h33, 1'b1, 3'd4, 32'h44);
        tick();
        n_checks++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL mid_fill got=%0d want=3", count); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({aluReady, ldReady} !== 2'b00) begin
            n_fail++; $display("FAIL mid_rst_ready got=%b want=00", {aluReady, ldReady});
        end
        tick();
        rst = 1'b0;
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        n_checks++;
        if ({count, regWrite} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL mid_rst cnt=%0d rw=%b want 0/0", count, regWrite);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (regWrite !== 1'b0) begin
                n_fail++; $display("FAIL mid_stale c=%0d rw=%b num=%0d want no write", c, regWrite, wrNum);
            end
        end
    endtask

    task automatic test_random();
        logic [69:0] obs_c, exp_c;
        logic [67:0] obs_r, exp_r;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 3) != 0, NW'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 2) != 0, NW'($urandom_range(0, 7)), $urandom);
            rdNumA = NW'($urandom_range(0, 7));
            rdNumB = NW'($urandom_range(0, 7));
            #1;
            obs_c = {aluReady, ldReady, hazardA, hazardB, fwdValidA, fwdValidB, fwdDataA, fwdDataB};
            exp_c = {exp_alu_ready(), exp_ld_ready(), exp_haz(rdNumA), exp_haz(rdNumB),
                     exp_haz(rdNumA) & BYP, exp_haz(rdNumB) & BYP, exp_fwd(rdNumA), exp_fwd(rdNumB)};
            n_checks++;
            if (obs_c !== exp_c) begin
                n_fail++; $display("FAIL rand_comb c=%0d got=%h want=%h", c, obs_c, exp_c);
            end
            tick();
            obs_r = {1'(0), count, regWrite, wrNum, wrData};
            exp_r = {1'(0), CW'(mq.size()), m_rw, m_num, m_data};
            n_checks++;
            if (obs_r !== exp_r) begin
                n_fail++; $display("FAIL rand_regs c=%0d got=%h want=%h", c, obs_r, exp_r);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        rdNumA = '0; rdNumB = '0;
        mq.delete();
        m_rw = 1'b0; m_num = '0; m_data = '0;
        test_reset();
        test_single_write();
        test_dual_accept();
        test_back_to_back();
        test_zero_reg();
        test_hazard_fwd();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
